fsmc_sdram_bridge: RTL

Register-mapped bridge between the clocked FSMC bus slave (`fsmc_*` strobes) and the SDRAM controller (`i_adv`/`i_rwn`/`o_busy` handshake). It is the parametrised successor of the single-word peripheral in `top`. It adds a posted write queue, a separate read-trigger register, optional address auto-increment, a status register with queue level, and a sticky overflow flag. Reads are always ordered after every queued write, so a read returns the value most recently written to that address.

---
 rtl/fsmc_sdram_bridge_pkg.sv | 35 +++
 rtl/fsmc_sdram_bridge_if.sv | 41 ++++
 rtl/fsmc_sdram_wq.sv | 48 ++++
 rtl/fsmc_sdram_bridge.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fsmc_sdram_bridge_pkg.sv
// fsmc_sdram_pkg: register map, STATUS/CMD bit positions and the bridge FSM
// state encoding, shared by the bridge, its write queue and its bench.
package fsmc_sdram_pkg;

    // Register word offsets
    localparam int REG_ADR_LOW  = 0;
    localparam int REG_ADR_HIGH = 1;
    localparam int REG_DATA     = 2;
    localparam int REG_CMD      = 3;
    localparam int REG_STATUS   = 4;

    // STATUS bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_INIT    = 3;
    localparam int ST_LVL_LSB = 8;
    localparam int ST_LVL_W   = 8;

    // CMD write bit positions
    localparam int CMD_RD      = 0;
    localparam int CMD_AUTOINC = 1;
    localparam int CMD_CLR_OVF = 2;
    // Position of autoinc in a CMD read: {.., autoinc, 2'b0}
    localparam int CMD_AUTOINC_RD = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT
    } state_t;

endpackage

// File: rtl/fsmc_sdram_bridge_if.sv
// FSMC register-bus and SDRAM-controller handshake signals of the bridge.
// slave  : the bridge side (FSMC bus slave, SDRAM request master).
// master : the surrounding system (FSMC core and SDRAM controller).
interface fsmc_sdram_bridge_if #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int MEM_AW = 24
);
    logic [AW-1:0]     fsmc_r_adr;
    logic [DW-1:0]     fsmc_r_data;
    logic              fsmc_do_write;
    logic [AW-1:0]     fsmc_w_adr;
    logic [DW-1:0]     fsmc_w_data;

    logic              sdram_init_done;
    logic              sdram_busy;
    logic              sdram_data_valid;
    logic              sdram_write_done;
    logic [DW-1:0]     sdram_rdata;
    logic              sdram_adv;
    logic              sdram_rwn;
    logic [MEM_AW-1:0] sdram_addr;
    logic [DW-1:0]     sdram_wdata;

    modport slave (
        input  fsmc_r_adr, fsmc_do_write, fsmc_w_adr, fsmc_w_data,
        input  sdram_init_done, sdram_busy, sdram_data_valid,
        input  sdram_write_done, sdram_rdata,
        output fsmc_r_data,
        output sdram_adv, sdram_rwn, sdram_addr, sdram_wdata
    );

    modport master (
        output fsmc_r_adr, fsmc_do_write, fsmc_w_adr, fsmc_w_data,
        output sdram_init_done, sdram_busy, sdram_data_valid,
        output sdram_write_done, sdram_rdata,
        input  fsmc_r_data,
        input  sdram_adv, sdram_rwn, sdram_addr, sdram_wdata
    );

endinterface

// File: rtl/fsmc_sdram_wq.sv
// fsmc_sdram_wq: synchronous posted-write FIFO. A push while full is
// accepted only when a pop happens in the same cycle; level counts entries.
module fsmc_sdram_wq #(
    parameter int W     = 40,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign level = LW'(wr_ptr - rd_ptr);
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr[PW-1:0]];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[PW-1:0]] <= wdata;
    end

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fsmc_sdram_bridge.sv
// fsmc_sdram_bridge: register-mapped FSMC -> SDRAM controller bridge with a
// posted write queue, read trigger, status and sticky overflow.
// Optional feature macro: FSMC_SDRAM_AUTOINC_EN (address auto-increment and
// CMD bit1); without it autoinc is tied to 0.
module fsmc_sdram_bridge
    import fsmc_sdram_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int MEM_AW   = 24,
    parameter int WQ_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    fsmc_sdram_bridge_if.slave   bus
);
    localparam int HW = MEM_AW - DW;          // width held by ADR_HIGH
    localparam int QW = MEM_AW + DW;          // queue entry {adr, data}
    localparam int LW = $clog2(WQ_DEPTH) + 1;

    state_t            state;
    logic [MEM_AW-1:0] adr, rd_adr;
    logic [DW-1:0]     rd_data;
    logic              rd_pend, overflow, autoinc;
    logic              adv_q, rwn_q;
    logic [MEM_AW-1:0] addr_q;
    logic [DW-1:0]     wdata_q;

    logic [QW-1:0]     q_head;
    logic              q_full, q_empty;
    logic [LW-1:0]     q_level;

    logic wr_adr_lo, wr_adr_hi, wr_data, wr_cmd;
    logic sdram_idle, q_pop, rd_start, rd_done;
    logic push_ok, rd_busy, cmd_rd, cmd_rd_ok, adr_inc, busy;

    // Write strobe decode
    assign wr_adr_lo = bus.fsmc_do_write && (bus.fsmc_w_adr == AW'(REG_ADR_LOW));
    assign wr_adr_hi = bus.fsmc_do_write && (bus.fsmc_w_adr == AW'(REG_ADR_HIGH));
    assign wr_data   = bus.fsmc_do_write && (bus.fsmc_w_adr == AW'(REG_DATA));
    assign wr_cmd    = bus.fsmc_do_write && (bus.fsmc_w_adr == AW'(REG_CMD));

    // Issue decisions are taken in IDLE; queued writes beat a pending read
    assign sdram_idle = bus.sdram_init_done && !bus.sdram_busy;
    assign q_pop      = (state == S_IDLE) && !q_empty && sdram_idle;
    assign rd_start   = (state == S_IDLE) && q_empty && rd_pend && sdram_idle;
    assign rd_done    = (state == S_RD_WAIT) && bus.sdram_data_valid;

    // A push into a full queue is still taken when the head leaves this cycle
    assign push_ok   = wr_data && (!q_full || q_pop);
    // rd_pend stays set through issue and wait, so it also covers in-flight
    assign rd_busy   = rd_pend || (state == S_RD_ISSUE) || (state == S_RD_WAIT);
    assign cmd_rd    = wr_cmd && bus.fsmc_w_data[CMD_RD];
    assign cmd_rd_ok = cmd_rd && !rd_busy;
    assign adr_inc   = autoinc && (push_ok || cmd_rd_ok);
    assign busy      = !q_empty || rd_pend || (state != S_IDLE);

    fsmc_sdram_wq #(
        .W     (QW),
        .DEPTH (WQ_DEPTH),
        .LW    (LW)
    ) u_wq (
        .clk   (clk),
        .nrst  (nrst),
        .push  (wr_data),
        .pop   (q_pop),
        .wdata ({adr, bus.fsmc_w_data}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .level (q_level)
    );

`ifdef FSMC_SDRAM_AUTOINC_EN
    // autoinc follows CMD bit1 on every CMD write
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            autoinc <= 1'b0;
        else if (wr_cmd)
            autoinc <= bus.fsmc_w_data[CMD_AUTOINC];
    end
`else
    assign autoinc = 1'b0;
`endif

    // Address register, read trigger and sticky overflow
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            adr      <= '0;
            rd_adr   <= '0;
            rd_pend  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_adr_lo)
                adr[DW-1:0] <= bus.fsmc_w_data;
            else if (wr_adr_hi)
                adr[MEM_AW-1:DW] <= bus.fsmc_w_data[HW-1:0];
            else if (adr_inc)
                adr <= adr + MEM_AW'(1);

            if (cmd_rd_ok)
                rd_adr <= adr;

            if (rd_done)
                rd_pend <= 1'b0;
            else if (cmd_rd_ok)
                rd_pend <= 1'b1;

            // Clear first so a rejected read in the same CMD still sets it
            if (wr_data && !push_ok)
                overflow <= 1'b1;
            if (wr_cmd && bus.fsmc_w_data[CMD_CLR_OVF])
                overflow <= 1'b0;
            if (cmd_rd && !cmd_rd_ok)
                overflow <= 1'b1;
        end
    end

    // Request FSM with registered SDRAM outputs held until back in IDLE
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            adv_q   <= 1'b0;
            rwn_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_data <= '0;
        end else begin
            adv_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (q_pop) begin
                        state   <= S_WR_ISSUE;
                        adv_q   <= 1'b1;
                        rwn_q   <= 1'b0;
                        addr_q  <= q_head[QW-1:DW];
                        wdata_q <= q_head[DW-1:0];
                    end else if (rd_start) begin
                        state  <= S_RD_ISSUE;
                        adv_q  <= 1'b1;
                        rwn_q  <= 1'b1;
                        addr_q <= rd_adr;
                    end
                end
                S_WR_ISSUE: state <= S_WR_WAIT;
                S_RD_ISSUE: state <= S_RD_WAIT;
                S_WR_WAIT: begin
                    if (bus.sdram_write_done)
                        state <= S_IDLE;
                end
                S_RD_WAIT: begin
                    if (bus.sdram_data_valid) begin
                        rd_data <= bus.sdram_rdata;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sdram_adv   = adv_q;
    assign bus.sdram_rwn   = rwn_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_wdata = wdata_q;

    // Side-effect-free register read decode
    always_comb begin
        bus.fsmc_r_data = '0;
        case (bus.fsmc_r_adr)
            AW'(REG_ADR_LOW):  bus.fsmc_r_data = adr[DW-1:0];
            AW'(REG_ADR_HIGH): bus.fsmc_r_data = DW'(adr[MEM_AW-1:DW]);
            AW'(REG_DATA):     bus.fsmc_r_data = rd_data;
            AW'(REG_CMD):      bus.fsmc_r_data[CMD_AUTOINC_RD] = autoinc;
            AW'(REG_STATUS): begin
                bus.fsmc_r_data[ST_BUSY] = busy;
                bus.fsmc_r_data[ST_FULL] = q_full;
                bus.fsmc_r_data[ST_OVF]  = overflow;
                bus.fsmc_r_data[ST_INIT] = bus.sdram_init_done;
                bus.fsmc_r_data[ST_LVL_LSB +: ST_LVL_W] = ST_LVL_W'(q_level);
            end
            default: bus.fsmc_r_data = '0;
        endcase
    end

endmodule
